// File: rtl/wb_camera_capture.sv
// wb_camera_capture: Wishbone-slave capture engine for an 8-bit parallel camera.
// Generates the sensor clock, synchronizes the pixel bus into clk, and stores
// frame bytes in an internal buffer readable over the same Wishbone port.
module wb_camera_capture #(
   parameter int BUF_AW      = 15,
   parameter int XCLK_DIV    = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        camera_xclk,
   input  logic        camera_pclk,
   input  logic        camera_vsync,
   input  logic        camera_href,
   input  logic [7:0]  camera_data
);

   localparam int XW = $clog2(XCLK_DIV) + 1;

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

   state_t            state;
   logic [BUF_AW:0]   wr_ptr;      // doubles as BYTE_CNT; top bit marks a full buffer
   logic [15:0]       frame_cnt;
   logic              done;
   logic              overflow;
   logic              continuous;
   logic              busy;

   logic [7:0]        mem [2**BUF_AW];

   logic [XW-1:0]     xclk_cnt;

   logic [SYNC_STAGES-1:0] pclk_sh;
   logic [SYNC_STAGES-1:0] vsync_sh;
   logic [SYNC_STAGES-1:0] href_sh;
   logic [7:0]             data_sh [SYNC_STAGES];
   logic                   pclk_prev;
   logic                   vsync_prev;
   logic                   pclk_s;
   logic                   vsync_s;
   logic                   href_s;
   logic [7:0]             data_s;
   logic                   pclk_rise;
   logic                   vsync_rise;
   logic                   vsync_fall;

   logic              req;
   logic              buf_sel;
   logic [1:0]        reg_idx;
   logic [BUF_AW-1:0] buf_idx;
   logic [31:0]       reg_rd;
   logic              ctrl_wr;
   logic              stat_wr;
   logic [2:0]        wr_bits;
   logic              start;
   logic              abort;
   logic              buf_we;
   logic              unused_ok;

   assign unused_ok = ^{wb_sel_i, wb_adr_i[31:BUF_AW+3], wb_adr_i[1:0], wb_dat_i[31:3]};

   assign busy       = (state != IDLE);
   assign pclk_s     = pclk_sh[SYNC_STAGES-1];
   assign vsync_s    = vsync_sh[SYNC_STAGES-1];
   assign href_s     = href_sh[SYNC_STAGES-1];
   assign data_s     = data_sh[SYNC_STAGES-1];
   assign pclk_rise  = pclk_s & ~pclk_prev;
   assign vsync_rise = vsync_s & ~vsync_prev;
   assign vsync_fall = ~vsync_s & vsync_prev;

   assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign buf_sel = wb_adr_i[BUF_AW+2];
   assign reg_idx = wb_adr_i[3:2];
   assign buf_idx = wb_adr_i[BUF_AW+1:2];

   // CTRL commands are registered at the request edge, so they act the cycle after ack
   assign start  = ctrl_wr & wr_bits[0];
   assign abort  = ctrl_wr & wr_bits[2];
   assign buf_we = (state == CAPTURE) & pclk_rise & href_s & ~wr_ptr[BUF_AW] & ~abort & ~reset;

   // Free-running sensor clock divider
   always_ff @(posedge clk) begin
      if (reset) begin
         xclk_cnt    <= '0;
         camera_xclk <= 1'b0;
      end else if (xclk_cnt == XW'(XCLK_DIV - 1)) begin
         xclk_cnt    <= '0;
         camera_xclk <= ~camera_xclk;
      end else begin
         xclk_cnt <= xclk_cnt + 1'b1;
      end
   end

   // Synchronize camera timing strobes and keep previous values for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         pclk_sh    <= '0;
         vsync_sh   <= '0;
         href_sh    <= '0;
         pclk_prev  <= 1'b0;
         vsync_prev <= 1'b0;
      end else begin
         pclk_sh    <= {pclk_sh[SYNC_STAGES-2:0], camera_pclk};
         vsync_sh   <= {vsync_sh[SYNC_STAGES-2:0], camera_vsync};
         href_sh    <= {href_sh[SYNC_STAGES-2:0], camera_href};
         pclk_prev  <= pclk_s;
         vsync_prev <= vsync_s;
      end
   end

   // Synchronize pixel data with the same depth so it stays aligned with pclk
   always_ff @(posedge clk) begin
      data_sh[0] <= camera_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sh[i] <= data_sh[i-1];
   end

   // Register read multiplexer
   always_comb begin
      reg_rd = '0;
      case (reg_idx)
         2'd0:    reg_rd = {30'b0, continuous, busy};
         2'd1:    reg_rd = {frame_cnt, 13'b0, overflow, done, busy};
         2'd2:    reg_rd = {{(31-BUF_AW){1'b0}}, wr_ptr};
         default: reg_rd = '0;
      endcase
   end

   // Wishbone slave: one-cycle registered ack, read data and write command capture
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         ctrl_wr  <= 1'b0;
         stat_wr  <= 1'b0;
      end else begin
         wb_ack_o <= req;
         ctrl_wr  <= req & wb_we_i & ~buf_sel & (reg_idx == 2'd0);
         stat_wr  <= req & wb_we_i & ~buf_sel & (reg_idx == 2'd1);
         if (req && !wb_we_i)
            wb_dat_o <= buf_sel ? {24'b0, mem[buf_idx]} : reg_rd;
      end
   end

   // Write payload for register commands
   always_ff @(posedge clk) begin
      if (req) wr_bits <= wb_dat_i[2:0];
   end

   // Capture buffer write port
   always_ff @(posedge clk) begin
      if (buf_we) mem[wr_ptr[BUF_AW-1:0]] <= data_s;
   end

   // Capture FSM with status flags and frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         frame_cnt  <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         continuous <= 1'b0;
      end else begin
         if (ctrl_wr) continuous <= wr_bits[1];
         if (stat_wr && wr_bits[1]) done <= 1'b0;
         if (stat_wr && wr_bits[2]) overflow <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state    <= ARM;
                     done     <= 1'b0;
                     overflow <= 1'b0;
                     wr_ptr   <= '0;
                  end
               end
               ARM: begin
                  if (vsync_fall) begin
                     state  <= CAPTURE;
                     wr_ptr <= '0;
                  end
               end
               CAPTURE: begin
                  if (pclk_rise && href_s) begin
                     if (!wr_ptr[BUF_AW]) wr_ptr <= wr_ptr + 1'b1;
                     else overflow <= 1'b1;
                  end
                  if (vsync_rise) begin
                     done      <= 1'b1;
                     frame_cnt <= frame_cnt + 16'd1;
                     state     <= continuous ? ARM : IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
